imem_byte_fetch: RTL and testbench

Instruction-fetch responder for the pipelined core. It serves the fetch address held in the program-counter register over a narrow 8-bit external memory bus and assembles four bytes into a little-endian 32-bit instruction. It presents that instruction to the decode stage. It also generates the PC enable, so the PC advances only when a complete instruction has been accepted or a redirect occurs.

---
 rtl/imem_fetch_pkg.sv | 10 +
 rtl/instr_byte_assembler.sv | 39 +++
 rtl/imem_byte_fetch.sv | 93 +++++++++
 tb/tb_imem_byte_fetch.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_fetch_pkg.sv
// Shared types and constants for the byte-serial instruction fetch block.
package imem_fetch_pkg;
  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR       = 32'h00000013;
  localparam int unsigned BYTES_PER_INSTR = 4;
endpackage

// File: rtl/instr_byte_assembler.sv
// Collects four bytes into a little-endian 32-bit word; done flags a full word.
module instr_byte_assembler
  import imem_fetch_pkg::*;
(
  input  logic        CLK,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        wr_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [1:0]  idx_o,
  output logic        done_o
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;
  logic        done_q;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
    end else if (clear_i) begin
      word_q <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
    end else if (wr_i) begin
      word_q[8*idx_q +: 8] <= byte_i;
      idx_q                <= idx_q + 2'd1;
      if (idx_q == 2'(BYTES_PER_INSTR - 1)) done_q <= 1'b1;
    end
  end

  assign word_o = word_q;
  assign idx_o  = idx_q;
  assign done_o = done_q;

endmodule

// File: rtl/imem_byte_fetch.sv
// Instruction-fetch responder: serial byte fetch over an 8-bit bus, decode
// handshake and PC enable generation.
module imem_byte_fetch
  import imem_fetch_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 16
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [31:0]          PCF,
  input  logic                 FlushF,
  input  logic                 StallD,
  output logic [31:0]          InstrF,
  output logic                 InstrValidF,
  output logic                 MisalignF,
  output logic                 EnF,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_req,
  input  logic                 mem_ack,
  input  logic [7:0]           mem_rdata
);

  fetch_state_e state_q;
  logic         mis_q;
  logic [31:0]  word;
  logic [1:0]   idx;
  logic         done;
  logic         misaligned_pc;
  logic         xfer;
  logic         accept;
  logic         unused_pcf;

  assign misaligned_pc = (idx == 2'd0) && (PCF[1:0] != 2'b00);
  assign mem_req       = !reset && !FlushF && (state_q == FETCH) && !misaligned_pc;
  assign xfer          = mem_req && mem_ack;
  assign accept        = (state_q == HOLD) && !StallD;
  assign EnF           = !reset && (accept || FlushF);
  assign unused_pcf    = ^PCF;

  generate
    if (ADDR_BITS > 2) begin : g_addr
      assign mem_addr = {PCF[ADDR_BITS-1:2], idx};
    end else begin : g_addr_narrow
      assign mem_addr = idx;
    end
  endgenerate

  // Accept and flush both wipe the lane register so a new fetch starts clean.
  instr_byte_assembler u_asm (
    .CLK     (CLK),
    .reset   (reset),
    .clear_i (FlushF || accept),
    .wr_i    (xfer),
    .byte_i  (mem_rdata),
    .word_o  (word),
    .idx_o   (idx),
    .done_o  (done)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      mis_q   <= 1'b0;
    end else if (FlushF) begin
      state_q <= FETCH;
      mis_q   <= 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (misaligned_pc) begin
            state_q <= HOLD;
            mis_q   <= 1'b1;
          end else if (xfer && (idx == 2'(BYTES_PER_INSTR - 1))) begin
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (!StallD) begin
            state_q <= FETCH;
            mis_q   <= 1'b0;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  // A misaligned hold never writes lanes, so the NOP is substituted here.
  assign InstrValidF = done || mis_q;
  assign MisalignF   = mis_q;
  assign InstrF      = mis_q ? NOP_INSTR : word;

endmodule

// File: tb/tb_imem_byte_fetch.sv
// Directed bench for imem_byte_fetch with a byte-queue reference model.
module tb_imem_byte_fetch;
  logic        CLK = 1'b0;
  logic        reset;
  logic [31:0] PCF;
  logic        FlushF, StallD;
  logic [31:0] InstrF;
  logic        InstrValidF, MisalignF, EnF;
  logic [15:0] mem_addr;
  logic        mem_req, mem_ack;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:65535];
  int          wait_n = 0;
  int          cnt = 0;
  logic [31:0] pc_init = 32'h100;
  logic [31:0] flush_tgt = 32'h0;
  int          n_pass = 0;
  int          n_total = 0;

  imem_byte_fetch #(.ADDR_BITS(16)) dut (
    .CLK(CLK), .reset(reset), .PCF(PCF), .FlushF(FlushF), .StallD(StallD),
    .InstrF(InstrF), .InstrValidF(InstrValidF), .MisalignF(MisalignF), .EnF(EnF),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  // Memory: ack after wait_n cycles of a held request.
  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = (cnt >= wait_n);
  always @(posedge CLK) begin
    if (mem_req && mem_ack) cnt <= 0;
    else if (mem_req)       cnt <= cnt + 1;
    else                    cnt <= 0;
  end

  // PC register: loads redirect target on flush, else steps by 4 on enable.
  always @(posedge CLK) begin
    if (reset)    PCF <= pc_init;
    else if (EnF) PCF <= FlushF ? flush_tgt : PCF + 32'd4;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: bytes gathered so far for the instruction in flight.
  logic [7:0]  q[$];
  bit          m_valid = 1'b0;
  bit          m_mis = 1'b0;
  logic [31:0] m_word = '0;

  function automatic bit exp_req();
    return !reset && !FlushF && !m_valid && !(q.size() == 0 && PCF[1:0] != 2'b00);
  endfunction

  function automatic logic [15:0] exp_addr();
    return 16'(PCF & ~32'h3) + 16'(q.size());
  endfunction

  always @(posedge CLK) begin
    if (reset) begin
      q.delete(); m_valid = 0; m_mis = 0; m_word = '0;
    end else if (FlushF) begin
      q.delete(); m_valid = 0; m_mis = 0;
    end else if (m_valid) begin
      if (!StallD) begin m_valid = 0; m_mis = 0; q.delete(); end
    end else if (q.size() == 0 && PCF[1:0] != 2'b00) begin
      m_valid = 1; m_mis = 1; m_word = 32'h00000013;
    end else if (mem_ack) begin
      q.push_back(mem[exp_addr()]);
      if (q.size() == 4) begin
        m_word = {q[3], q[2], q[1], q[0]};
        m_valid = 1;
        q.delete();
      end
    end
  end

  always @(negedge CLK) begin
    if (reset) begin
      chk("rst_instr", InstrF, 32'h0);
      chk("rst_valid", InstrValidF, 0);
      chk("rst_mis",   MisalignF, 0);
      chk("rst_enf",   EnF, 0);
      chk("rst_req",   mem_req, 0);
    end else begin
      chk("valid", InstrValidF, m_valid);
      chk("mis",   MisalignF, m_mis);
      chk("enf",   EnF, (m_valid && !StallD) || FlushF);
      chk("req",   mem_req, exp_req());
      if (exp_req()) chk("addr", mem_addr, exp_addr());
      if (m_valid)   chk("instr", InstrF, m_word);
    end
  end

  task automatic tick();
    @(posedge CLK); #2;
  endtask

  task automatic wait_valid(input int maxc, output int n);
    n = 0;
    while (!InstrValidF && n < maxc) begin tick(); n++; end
    if (!InstrValidF) chk("valid_timeout", InstrValidF, 1);
  endtask

  task automatic do_flush(input logic [31:0] tgt);
    flush_tgt = tgt; FlushF = 1; #1;
    chk("flush_req", mem_req, 0);
    chk("flush_enf", EnF, 1);
    tick(); FlushF = 0; #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [31:0] held;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
    {mem[16'h103], mem[16'h102], mem[16'h101], mem[16'h100]} = 32'h00100513;
    {mem[16'h043], mem[16'h042], mem[16'h041], mem[16'h040]} = 32'h563412B7;
    {mem[16'h203], mem[16'h202], mem[16'h201], mem[16'h200]} = 32'hDDCCBBAA;
    {mem[16'h303], mem[16'h302], mem[16'h301], mem[16'h300]} = 32'h0080006F;

    reset = 1; FlushF = 0; StallD = 0;
    repeat (3) tick();
    chk("reset_req", mem_req, 0);
    reset = 0; #1;

    // Zero-wait fetch from 0x100: valid in cycle 5 together with EnF.
    chk("zw_first_addr", mem_addr, 16'h0100);
    wait_valid(20, n);
    chk("zw_cycles", n, 4);
    chk("zw_instr", InstrF, 32'h00100513);
    chk("zw_enf", EnF, 1);
    tick();

    // Decode stall for 3 cycles on the instruction at 0x104.
    StallD = 1;
    wait_valid(20, n);
    held = InstrF;
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", InstrValidF, 1);
      chk("stall_instr", InstrF, held);
      chk("stall_enf", EnF, 0);
      tick();
    end
    StallD = 0; #1;
    chk("unstall_enf", EnF, 1);
    tick();
    chk("unstall_req", mem_req, 1);
    chk("unstall_addr", mem_addr, 16'h0108);

    // Two wait cycles per byte at 0x40: valid in cycle 13.
    wait_n = 2;
    do_flush(32'h40);
    chk("ws_first_addr", mem_addr, 16'h0040);
    wait_valid(40, n);
    chk("ws_cycles", n, 12);
    chk("ws_instr", InstrF, 32'h563412B7);
    wait_n = 0;
    tick();

    // Flush after two bytes of 0x200, redirect to 0x300.
    do_flush(32'h200);
    tick(); tick();
    do_flush(32'h300);
    chk("fl_req", mem_req, 1);
    chk("fl_addr", mem_addr, 16'h0300);
    wait_valid(20, n);
    chk("fl_cycles", n, 4);
    chk("fl_instr", InstrF, 32'h0080006F);
    tick();

    // Misaligned PC: no request, then NOP with MisalignF.
    do_flush(32'h102);
    chk("mis_req", mem_req, 0);
    tick();
    chk("mis_instr", InstrF, 32'h00000013);
    chk("mis_flag", MisalignF, 1);
    chk("mis_valid", InstrValidF, 1);

    // Reset after the third byte of 0x100.
    do_flush(32'h100);
    tick(); tick(); tick();
    reset = 1; #1;
    chk("mrst_instr", InstrF, 32'h0);
    chk("mrst_valid", InstrValidF, 0);
    chk("mrst_enf", EnF, 0);
    chk("mrst_req", mem_req, 0);
    tick(); tick();
    reset = 0; #1;
    chk("rel_req", mem_req, 1);
    chk("rel_addr", mem_addr, 16'h0100);
    wait_valid(20, n);
    chk("rel_cycles", n, 4);
    chk("rel_instr", InstrF, 32'h00100513);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
